pwm_capture: RTL

PWM_CAPTURE -- requirements
Module: pwm_capture

---
 rtl/pwm_capture.sv | 132 +++++++++++++
 1 files changed

// File: rtl/pwm_capture.sv
// PWM duty/period meter: synchronizes pwm_in, measures high time and
// rise-to-rise period in clk cycles, flags sticky timeout on no edges.
module pwm_capture #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] duty,
  output logic [WIDTH-1:0] period,
  output logic             valid,
  output logic             timeout
);

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW
  } state_e;

  localparam logic [WIDTH-1:0] MAX = '1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic s1_q, s2_q, s3_q;
  logic rise_d, rise_q;
  logic fall_d, fall_q;

  state_e           state_d, state_q;
  logic [WIDTH-1:0] high_d, high_q;
  logic [WIDTH-1:0] per_d, per_q;
  logic [WIDTH-1:0] duty_d, duty_q;
  logic [WIDTH-1:0] period_d, period_q;
  logic             valid_d, valid_q;
  logic             timeout_d, timeout_q;

  always_comb begin
    rise_d = s2_q & ~s3_q;
    fall_d = ~s2_q & s3_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s3_q   <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= pwm_in;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  // A rise at the counter limit still closes the period normally.
  always_comb begin
    state_d   = state_q;
    high_d    = high_q;
    per_d     = per_q;
    duty_d    = duty_q;
    period_d  = period_q;
    valid_d   = 1'b0;
    timeout_d = timeout_q;
    unique case (state_q)
      IDLE: begin
        if (rise_q) begin
          state_d = HIGH;
          high_d  = ONE;
          per_d   = ONE;
        end
      end
      HIGH: begin
        if (per_q == MAX) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else begin
          per_d = per_q + ONE;
          if (fall_q) begin
            state_d = LOW;
          end else begin
            high_d = high_q + ONE;
          end
        end
      end
      LOW: begin
        if (rise_q) begin
          state_d   = HIGH;
          duty_d    = high_q;
          period_d  = per_q;
          valid_d   = 1'b1;
          timeout_d = 1'b0;
          high_d    = ONE;
          per_d     = ONE;
        end else if (per_q == MAX) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else begin
          per_d = per_q + ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      high_q    <= '0;
      per_q     <= '0;
      duty_q    <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      high_q    <= high_d;
      per_q     <= per_d;
      duty_q    <= duty_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  assign duty    = duty_q;
  assign period  = period_q;
  assign valid   = valid_q;
  assign timeout = timeout_q;

endmodule
